stream_demux_1to2: RTL and testbench
====================================

// Module: stream_demux_1to2
// PURPOSE
//  Packet-aware 1-to-2 stream demultiplexer; the splitting counterpart of the 2:1 mux.
//  Routes each input packet to out0 or out1 according to s0, sampled on the first beat.
//  Each output has a one-entry registered stage with valid/ready handshake.
//  Sits between a single producer and two downstream consumers in the datapath.
// PARAMETERS
//  DW  8  data width in bits
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  s0          in   1   route select (0 -> out0, 1 -> out1), sampled on first beat only
//  in_valid    in   1   input beat valid
//  in_ready    out  1   input beat accepted when in_valid & in_ready
//  in_data     in   DW  input beat data
//  in_last     in   1   last beat of packet
//  out0_valid  out  1   out0 beat valid
//  out0_ready  in   1   out0 consumer ready
//  out0_data   out  DW  out0 beat data
//  out0_last   out  1   out0 last-beat flag
//  out1_valid  out  1   out1 beat valid
//  out1_ready  in   1   out1 consumer ready
//  out1_data   out  DW  out1 beat data
//  out1_last   out  1   out1 last-beat flag
// BEHAVIOUR
//  - Reset: state=IDLE, out*_valid=0, out*_data=0, out*_last=0; no beat survives reset.
//  - FSM: IDLE, ROUTE0, ROUTE1.
//    IDLE: target=s0. Accepted beat with in_last=0 -> ROUTE<s0>; in_last=1 -> stay IDLE.
//    ROUTEn: target=n; s0 ignored. Accepted beat with in_last=1 -> IDLE.
//  - in_ready (combinational) = ~target_valid | target_ready; independent of in_valid.
//  - Accept: target stage loads in_data/in_last, target_valid=1 next edge.
//  - Latency: 1 cycle accept -> out valid; throughput 1 beat/cycle with ready held high.
//  - Drain: out_valid clears on out_valid & out_ready with no new load the same edge;
//    simultaneous drain+load keeps valid=1 with new data.
//  - Hold: while out_valid & ~out_ready, data/last must not change.
//  - Non-target output drains independently; never loaded, never stalls input.
//  - s0 toggling mid-packet has no effect; s0 X ignored outside IDLE accept.
//  - Async reset mid-packet returns to IDLE and clears both stages immediately.
// CONFIGURATION
//  STREAM_DEMUX_CNT_EN defined: adds out  16  pkt_cnt0, pkt_cnt1; each increments on
//   its output's handshake with last=1, saturates at 16'hFFFF, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset: rst_n=0 mid-packet -> all out*_valid=0, in_ready=1 next cycle, state IDLE.
//  - s0=0, 3-beat pkt A1,A2,A3(last), out0_ready=1 -> out0 gets A1..A3 on 3
//    consecutive cycles starting 1 cycle after first accept; out1_valid stays 0.
//  - s0=1 on first beat then s0=0 during beats 2-4 -> all 4 beats on out1.
//  - out1_ready=0 with beat held: in_ready=0, out1_data stable; out1_ready=1 ->
//    beat drains, next beat accepted same cycle.
//  - Single-beat pkts alternating s0=0,1,0 (in_last=1) -> out0,out1,out0; FSM stays IDLE.
//  - STREAM_DEMUX_CNT_EN: 2 pkts to out0, 1 to out1 -> pkt_cnt0=2, pkt_cnt1=1.

Source files
------------

// File: rtl/stream_demux_1to2.sv
// Packet-aware 1-to-2 stream demultiplexer with a one-entry registered stage per output.
// Optional macro STREAM_DEMUX_CNT_EN adds saturating per-output packet counters.
module stream_demux_1to2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s0,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out0_data,
    output logic          out0_last,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [DW-1:0] out1_data,
    output logic          out1_last
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [15:0]   pkt_cnt0,
    output logic [15:0]   pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          target_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          load0_s;
    logic          load1_s;

    logic          out0_valid_r;
    logic [DW-1:0] out0_data_r;
    logic          out0_last_r;
    logic          out1_valid_r;
    logic [DW-1:0] out1_data_r;
    logic          out1_last_r;

    // Select the target stage: s0 only matters on a packet's first beat.
    always_comb begin
        target_s = 1'b0;
        case (state_r)
            IDLE:    target_s = s0;
            ROUTE0:  target_s = 1'b0;
            ROUTE1:  target_s = 1'b1;
            default: target_s = 1'b0;
        endcase
    end

    // Ready depends only on the target stage, so the idle output never stalls input.
    always_comb begin
        in_ready_s = 1'b0;
        if (target_s) begin
            in_ready_s = ~out1_valid_r | out1_ready;
        end else begin
            in_ready_s = ~out0_valid_r | out0_ready;
        end
    end

    assign accept_s = in_valid & in_ready_s;
    assign load0_s  = accept_s & ~target_s;
    assign load1_s  = accept_s &  target_s;

    // Next-state: a non-last beat locks the route until the last beat is accepted.
    always_comb begin
        state_s = state_r;
        if (accept_s) begin
            if (in_last) begin
                state_s = IDLE;
            end else if (target_s) begin
                state_s = ROUTE1;
            end else begin
                state_s = ROUTE0;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Output stage 0: load wins over drain so back-to-back beats keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_valid_r <= 1'b0;
            out0_data_r  <= {DW{1'b0}};
            out0_last_r  <= 1'b0;
        end else if (load0_s) begin
            out0_valid_r <= 1'b1;
            out0_data_r  <= in_data;
            out0_last_r  <= in_last;
        end else if (out0_valid_r && out0_ready) begin
            out0_valid_r <= 1'b0;
        end else begin
            out0_valid_r <= out0_valid_r;
        end
    end

    // Output stage 1: same structure as stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_valid_r <= 1'b0;
            out1_data_r  <= {DW{1'b0}};
            out1_last_r  <= 1'b0;
        end else if (load1_s) begin
            out1_valid_r <= 1'b1;
            out1_data_r  <= in_data;
            out1_last_r  <= in_last;
        end else if (out1_valid_r && out1_ready) begin
            out1_valid_r <= 1'b0;
        end else begin
            out1_valid_r <= out1_valid_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out0_valid = out0_valid_r;
    assign out0_data  = out0_data_r;
    assign out0_last  = out0_last_r;
    assign out1_valid = out1_valid_r;
    assign out1_data  = out1_data_r;
    assign out1_last  = out1_last_r;

`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0] pkt_cnt0_r;
    logic [15:0] pkt_cnt1_r;

    // Count packets leaving each output, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0_r <= 16'd0;
            pkt_cnt1_r <= 16'd0;
        end else begin
            if (out0_valid_r && out0_ready && out0_last_r && (pkt_cnt0_r != 16'hFFFF)) begin
                pkt_cnt0_r <= pkt_cnt0_r + 16'd1;
            end
            if (out1_valid_r && out1_ready && out1_last_r && (pkt_cnt1_r != 16'hFFFF)) begin
                pkt_cnt1_r <= pkt_cnt1_r + 16'd1;
            end
        end
    end

    assign pkt_cnt0 = pkt_cnt0_r;
    assign pkt_cnt1 = pkt_cnt1_r;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Self-checking bench for stream_demux_1to2: directed vector table, hand-written
// reset sequence, then randomized traffic against a packet-level reference model.
module tb_stream_demux_1to2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s0;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out0_valid;
    logic          out0_ready;
    logic [DW-1:0] out0_data;
    logic          out0_last;
    logic          out1_valid;
    logic          out1_ready;
    logic [DW-1:0] out1_data;
    logic          out1_last;
`ifdef STREAM_DEMUX_CNT_EN
    logic [15:0]   pkt_cnt0;
    logic [15:0]   pkt_cnt1;
`endif

    always #5 clk = ~clk;

    stream_demux_1to2 #(.DW(DW)) dut (
`ifdef STREAM_DEMUX_CNT_EN
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .s0         (s0),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          s0, v;
        logic [DW-1:0] d;
        logic          l, r0, r1;
        logic          e_rdy, e_v0;
        logic [DW-1:0] e_d0;
        logic          e_l0, e_v1;
        logic [DW-1:0] e_d1;
        logic          e_l1;
    } vec_t;

    function automatic vec_t mk(input logic s0_i, input logic v_i, input logic [DW-1:0] d_i,
                                input logic l_i, input logic r0_i, input logic r1_i,
                                input logic rdy, input logic v0, input logic [DW-1:0] d0,
                                input logic l0, input logic v1, input logic [DW-1:0] d1,
                                input logic l1);
        vec_t t;
        t.s0 = s0_i; t.v = v_i; t.d = d_i; t.l = l_i; t.r0 = r0_i; t.r1 = r1_i;
        t.e_rdy = rdy; t.e_v0 = v0; t.e_d0 = d0; t.e_l0 = l0;
        t.e_v1 = v1; t.e_d1 = d1; t.e_l1 = l1;
        return t;
    endfunction

    task automatic drive(input logic s0_i, input logic v_i, input logic [DW-1:0] d_i,
                         input logic l_i, input logic r0_i, input logic r1_i);
        s0 = s0_i; in_valid = v_i; in_data = d_i; in_last = l_i;
        out0_ready = r0_i; out1_ready = r1_i;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[21];

    // Reference model: one-entry buffer per output, packet route fixed by first beat.
    logic          m_occ0, m_occ1, m_l0, m_l1, m_mid, m_dest;
    logic [DW-1:0] m_d0, m_d1;
    int            m_c0, m_c1;

    initial begin
        // s0 r/v data last r0 r1 | rdy v0 d0 l0 v1 d1 l1
        tbl[0]  = mk(0,0,8'h00,0,1,1, 1,0,8'h00,0,0,8'h00,0);
        tbl[1]  = mk(0,1,8'hA1,0,1,1, 1,0,8'h00,0,0,8'h00,0);
        tbl[2]  = mk(1,1,8'hA2,0,1,1, 1,1,8'hA1,0,0,8'h00,0);
        tbl[3]  = mk(1,1,8'hA3,1,1,1, 1,1,8'hA2,0,0,8'h00,0);
        tbl[4]  = mk(0,0,8'h00,0,1,1, 1,1,8'hA3,1,0,8'h00,0);
        tbl[5]  = mk(0,0,8'h00,0,1,1, 1,0,8'h00,0,0,8'h00,0);
        tbl[6]  = mk(1,1,8'hB1,0,1,1, 1,0,8'h00,0,0,8'h00,0);
        tbl[7]  = mk(0,1,8'hB2,0,1,1, 1,0,8'h00,0,1,8'hB1,0);
        tbl[8]  = mk(0,1,8'hB3,0,1,1, 1,0,8'h00,0,1,8'hB2,0);
        tbl[9]  = mk(0,1,8'hB4,1,1,1, 1,0,8'h00,0,1,8'hB3,0);
        tbl[10] = mk(0,0,8'h00,0,1,1, 1,0,8'h00,0,1,8'hB4,1);
        tbl[11] = mk(1,1,8'hC1,0,1,0, 1,0,8'h00,0,0,8'h00,0);
        tbl[12] = mk(0,1,8'hC2,1,1,0, 0,0,8'h00,0,1,8'hC1,0);
        tbl[13] = mk(0,1,8'hC2,1,1,0, 0,0,8'h00,0,1,8'hC1,0);
        tbl[14] = mk(0,1,8'hC2,1,1,1, 1,0,8'h00,0,1,8'hC1,0);
        tbl[15] = mk(0,0,8'h00,0,1,1, 1,0,8'h00,0,1,8'hC2,1);
        tbl[16] = mk(0,1,8'hD1,1,1,1, 1,0,8'h00,0,0,8'h00,0);
        tbl[17] = mk(1,1,8'hD2,1,1,1, 1,1,8'hD1,1,0,8'h00,0);
        tbl[18] = mk(0,1,8'hD3,1,1,1, 1,0,8'h00,0,1,8'hD2,1);
        tbl[19] = mk(0,0,8'h00,0,1,1, 1,1,8'hD3,1,0,8'h00,0);
        tbl[20] = mk(0,0,8'h00,0,1,1, 1,0,8'h00,0,0,8'h00,0);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("reset_out0_data", out0_data, 8'h00);
        chk("reset_out0_last", out0_last, 1'b0);
        chk("reset_out1_data", out1_data, 8'h00);
        chk("reset_out1_last", out1_last, 1'b0);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].s0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_out0_valid", i), out0_valid, tbl[i].e_v0);
            chk($sformatf("tbl%0d_out1_valid", i), out1_valid, tbl[i].e_v1);
            if (tbl[i].e_v0) begin
                chk($sformatf("tbl%0d_out0_data", i), out0_data, tbl[i].e_d0);
                chk($sformatf("tbl%0d_out0_last", i), out0_last, tbl[i].e_l0);
            end
            if (tbl[i].e_v1) begin
                chk($sformatf("tbl%0d_out1_data", i), out1_data, tbl[i].e_d1);
                chk($sformatf("tbl%0d_out1_last", i), out1_last, tbl[i].e_l1);
            end
            next_cycle();
        end
`ifdef STREAM_DEMUX_CNT_EN
        chk("pkt_cnt0_directed", pkt_cnt0, 16'd3);
        chk("pkt_cnt1_directed", pkt_cnt1, 16'd3);
`endif

        // Reset in the middle of a packet routed to out0 (out0 stalled).
        drive(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        chk("midpkt_out0_valid", out0_valid, 1'b1);
        chk("midpkt_out0_data", out0_data, 8'hE1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out0_valid", out0_valid, 1'b0);
        chk("async_rst_out1_valid", out1_valid, 1'b0);
        chk("async_rst_out0_data", out0_data, 8'h00);
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 8'hF1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
`ifdef STREAM_DEMUX_CNT_EN
        chk("post_rst_pkt_cnt0", pkt_cnt0, 16'd0);
`endif
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        #1;
        chk("post_rst_idle_out1_valid", out1_valid, 1'b1);
        chk("post_rst_idle_out1_data", out1_data, 8'hF1);
        chk("post_rst_idle_out0_valid", out0_valid, 1'b0);
        next_cycle();

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        m_occ0 = 0; m_occ1 = 0; m_l0 = 0; m_l1 = 0; m_mid = 0; m_dest = 0;
        m_d0 = '0; m_d1 = '0; m_c0 = 0; m_c1 = 0;
        for (int c = 0; c < 3000; c++) begin
            logic tgt, e_rdy, acc;
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0));
            #1;
            tgt   = m_mid ? m_dest : s0;
            e_rdy = tgt ? (!m_occ1 || out1_ready) : (!m_occ0 || out0_ready);
            chk("rnd_in_ready", in_ready, e_rdy);
            chk("rnd_out0_valid", out0_valid, m_occ0);
            chk("rnd_out1_valid", out1_valid, m_occ1);
            if (m_occ0) begin
                chk("rnd_out0_data", out0_data, m_d0);
                chk("rnd_out0_last", out0_last, m_l0);
            end
            if (m_occ1) begin
                chk("rnd_out1_data", out1_data, m_d1);
                chk("rnd_out1_last", out1_last, m_l1);
            end
`ifdef STREAM_DEMUX_CNT_EN
            chk("rnd_pkt_cnt0", pkt_cnt0, 32'(m_c0));
            chk("rnd_pkt_cnt1", pkt_cnt1, 32'(m_c1));
`endif
            acc = in_valid && e_rdy;
            if (m_occ0 && out0_ready) begin
                m_occ0 = 0;
                if (m_l0 && m_c0 < 65535) m_c0++;
            end
            if (m_occ1 && out1_ready) begin
                m_occ1 = 0;
                if (m_l1 && m_c1 < 65535) m_c1++;
            end
            if (acc) begin
                if (tgt) begin
                    m_occ1 = 1; m_d1 = in_data; m_l1 = in_last;
                end else begin
                    m_occ0 = 1; m_d0 = in_data; m_l0 = in_last;
                end
                m_mid  = !in_last;
                m_dest = tgt;
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
